gp_trig_scheduler: RTL and testbench

- Sits between the GP engine trigger inputs and the command-sequencing FSM.
- Detects trigger rising edges and counts pending triggers per source.
- Arbitrates pending sources round-robin and issues one sequence request at a time over a valid/ready handshake.
- Tracks each sequence until done or timeout, and reports per-source pending and overflow status.

---
 rtl/gp_trig_scheduler.sv | 94 +++++++++
 tb/tb_gp_trig_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gp_trig_scheduler.sv
// gp_trig_scheduler: counts trigger rising edges per source and issues round-robin sequence requests with done/timeout tracking.
module gp_trig_scheduler #(
  parameter int NO_TRIG_SR     = 4,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SRC_W          = $clog2(NO_TRIG_SR)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NO_TRIG_SR-1:0] i_str_trig,
  input  logic [NO_TRIG_SR-1:0] i_trig_en,
  input  logic [NO_TRIG_SR-1:0] i_ovf_clr,
  output logic                  o_req_valid,
  output logic [SRC_W-1:0]      o_req_src,
  output logic [NO_TRIG_SR-1:0] o_req_onehot,
  input  logic                  i_req_ready,
  input  logic                  i_done,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic [NO_TRIG_SR-1:0] o_pending,
  output logic [NO_TRIG_SR-1:0] o_ovf
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLIM = TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLIM_W = TLIM[TW-1:0];
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;
  state_t state, state_n;
  logic [NO_TRIG_SR-1:0] trig_q, rise, elig, ovf_n, onehot_n;
  logic [CNT_WIDTH-1:0]  cnt   [NO_TRIG_SR];
  logic [CNT_WIDTH-1:0]  cnt_n [NO_TRIG_SR];
  logic [SRC_W-1:0]      ptr, ptr_n, win, src_n;
  logic [TW-1:0]         tcnt;
  logic                  any, accept, tmo_hit;
  assign rise    = i_str_trig & ~trig_q & i_trig_en;
  assign accept  = state == GRANT && i_req_ready;
  assign tmo_hit = state == BUSY && TIMEOUT_CYCLES != 0 && tcnt == TLIM_W;
  assign any     = |elig;
  // A source parked in GRANT keeps its count through a disable until it is accepted.
  for (genvar i = 0; i < NO_TRIG_SR; i++) begin : g_src
    logic held, dec, full;
    assign held         = state == GRANT && o_req_src == SRC_W'(i);
    assign dec          = held && i_req_ready;
    assign full         = &cnt[i];
    assign elig[i]      = cnt[i] != '0 && i_trig_en[i];
    assign o_pending[i] = cnt[i] != '0;
    assign cnt_n[i]     = !i_trig_en[i] && !held ? '0 :
                          rise[i] && !dec && !full ? cnt[i] + 1'b1 :
                          dec && !rise[i] ? cnt[i] - 1'b1 : cnt[i];
    assign ovf_n[i]     = (rise[i] && !dec && full) || (o_ovf[i] && !i_ovf_clr[i]);
  end
  // Iterate from the farthest offset down so the first eligible index after ptr wins.
  always_comb begin
    win = '0;
    for (int k = NO_TRIG_SR - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % NO_TRIG_SR]) win = SRC_W'((int'(ptr) + k) % NO_TRIG_SR);
  end
  always_comb begin
    state_n = state == IDLE  ? (any ? GRANT : IDLE) :
              state == GRANT ? (i_req_ready ? BUSY : GRANT) :
              (i_done || tmo_hit) ? IDLE : BUSY;
  end
  always_comb begin
    src_n    = state == IDLE && any ? win : o_req_src;
    onehot_n = state_n == GRANT ? NO_TRIG_SR'(1) << src_n : '0;
    ptr_n    = !accept ? ptr : o_req_src == SRC_W'(NO_TRIG_SR - 1) ? '0 : o_req_src + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      trig_q       <= '0;
      ptr          <= '0;
      tcnt         <= '0;
      cnt          <= '{default: '0};
      o_ovf        <= '0;
      o_req_valid  <= 1'b0;
      o_req_src    <= '0;
      o_req_onehot <= '0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_n;
      trig_q       <= i_str_trig;
      ptr          <= ptr_n;
      tcnt         <= accept ? '0 : state == BUSY ? tcnt + 1'b1 : tcnt;
      cnt          <= cnt_n;
      o_ovf        <= ovf_n;
      o_req_valid  <= state_n == GRANT;
      o_req_src    <= src_n;
      o_req_onehot <= onehot_n;
      o_busy       <= state_n != IDLE;
      o_timeout    <= tmo_hit && !i_done;
    end
  end
endmodule

// File: tb/tb_gp_trig_scheduler.sv
// tb_gp_trig_scheduler: table-driven vectors plus directed sequences for saturation, timeout, disable and reset.
module tb_gp_trig_scheduler;
  logic       clk = 1'b0;
  logic       rst, req_ready, done;
  logic [3:0] str_trig, trig_en, ovf_clr;
  logic       o_req_valid, o_busy, o_timeout;
  logic [1:0] o_req_src;
  logic [3:0] o_req_onehot, o_pending, o_ovf;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  gp_trig_scheduler #(.NO_TRIG_SR(4), .CNT_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_str_trig(str_trig), .i_trig_en(trig_en), .i_ovf_clr(ovf_clr),
    .o_req_valid(o_req_valid), .o_req_src(o_req_src), .o_req_onehot(o_req_onehot),
    .i_req_ready(req_ready), .i_done(done), .o_busy(o_busy), .o_timeout(o_timeout),
    .o_pending(o_pending), .o_ovf(o_ovf)
  );
  typedef struct {
    logic       rst;
    logic [3:0] trig;
    logic       done;
    logic       valid;
    logic [1:0] src;
    logic [3:0] onehot;
    logic       busy;
    logic [3:0] pend;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic r, logic [3:0] t, logic d, logic va, logic [1:0] s,
                             logic [3:0] oh, logic b, logic [3:0] p);
    vec_t x;
    x.rst = r; x.trig = t; x.done = d; x.valid = va; x.src = s; x.onehot = oh; x.busy = b; x.pend = p;
    return x;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  initial begin
    int g0, g1, tp;
    rst = 1'b1; str_trig = '0; trig_en = 4'hf; ovf_clr = '0; req_ready = 1'b1; done = 1'b0;
    // single source on src2
    tbl.push_back(v(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000));
    tbl.push_back(v(0, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'b0100));
    tbl.push_back(v(0, 4'b0100, 0, 1, 2, 4'b0100, 1, 4'b0100));
    tbl.push_back(v(0, 4'b0000, 0, 0, 2, 4'b0000, 1, 4'b0000));
    for (int n = 0; n < 4; n++) tbl.push_back(v(0, 4'b0000, 0, 0, 2, 4'b0000, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2, 4'b0000, 0, 4'b0000));
    // round robin over all four
    tbl.push_back(v(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000));
    tbl.push_back(v(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 4'b1111));
    tbl.push_back(v(0, 4'b0000, 0, 1, 0, 4'b0001, 1, 4'b1111));
    tbl.push_back(v(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b1110));
    tbl.push_back(v(0, 4'b0000, 0, 0, 0, 4'b0000, 1, 4'b1110));
    tbl.push_back(v(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b1110));
    tbl.push_back(v(0, 4'b0000, 0, 1, 1, 4'b0010, 1, 4'b1110));
    tbl.push_back(v(0, 4'b0000, 0, 0, 1, 4'b0000, 1, 4'b1100));
    tbl.push_back(v(0, 4'b0000, 0, 0, 1, 4'b0000, 1, 4'b1100));
    tbl.push_back(v(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 4'b1100));
    tbl.push_back(v(0, 4'b0000, 0, 1, 2, 4'b0100, 1, 4'b1100));
    tbl.push_back(v(0, 4'b0000, 0, 0, 2, 4'b0000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 0, 0, 2, 4'b0000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 1, 0, 2, 4'b0000, 0, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 0, 1, 3, 4'b1000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 0, 0, 3, 4'b0000, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 0, 0, 3, 4'b0000, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 1, 0, 3, 4'b0000, 0, 4'b0000));
    // src1 + src3 with ptr=0, then re-trigger after src1 grant
    tbl.push_back(v(0, 4'b1010, 0, 0, 3, 4'b0000, 0, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 1, 1, 4'b0010, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 0, 1, 4'b0000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b1010, 0, 0, 1, 4'b0000, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 1, 3, 4'b1000, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 0, 3, 4'b0000, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 1, 0, 3, 4'b0000, 0, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 1, 1, 4'b0010, 1, 4'b1010));
    tbl.push_back(v(0, 4'b0000, 0, 0, 1, 4'b0000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 0, 1, 3, 4'b1000, 1, 4'b1000));
    tbl.push_back(v(0, 4'b0000, 0, 0, 3, 4'b0000, 1, 4'b0000));
    tbl.push_back(v(0, 4'b0000, 1, 0, 3, 4'b0000, 0, 4'b0000));
    foreach (tbl[n]) begin
      rst = tbl[n].rst; str_trig = tbl[n].trig; done = tbl[n].done;
      tick();
      chk($sformatf("vec%0d", n),
          {o_req_valid, o_req_src, o_req_onehot, o_busy, o_timeout, o_pending, o_ovf},
          {tbl[n].valid, tbl[n].src, tbl[n].onehot, tbl[n].busy, 1'b0, tbl[n].pend, 4'b0000});
    end
    rst = 1'b0; str_trig = '0; done = 1'b0;
    // saturation while src0 is stalled in GRANT
    rst = 1'b1; tick(); rst = 1'b0; req_ready = 1'b0;
    str_trig = 4'b0001; tick(); str_trig = '0; tick();
    chk("sat_hold_src0", {o_req_valid, o_req_src}, {1'b1, 2'd0});
    for (int r = 1; r <= 17; r++) begin
      str_trig[1] = 1'b1; tick(); str_trig[1] = 1'b0; tick();
      if (r == 15) chk("sat_no_ovf_15", 32'(o_ovf[1]), 0);
      if (r == 16) chk("sat_ovf_16", 32'(o_ovf[1]), 1);
    end
    chk("sat_pending", o_pending, 4'b0011);
    ovf_clr = 4'b0010; tick(); ovf_clr = '0;
    chk("ovf_clr", o_ovf, 0);
    str_trig[1] = 1'b1; ovf_clr = 4'b0010; tick(); ovf_clr = '0; str_trig[1] = 1'b0;
    chk("clr_vs_set", o_ovf, 4'b0010);
    ovf_clr = 4'b0010; tick(); ovf_clr = '0;
    req_ready = 1'b1; done = 1'b1; g0 = 0; g1 = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (o_req_valid) begin
        if (o_req_src == 2'd1) g1++;
        else g0++;
      end
    end
    chk("sat_grants_src1", g1, 15);
    chk("sat_grants_other", g0, 0);
    chk("sat_drained", o_pending, 0);
    // timeout after 8 busy cycles
    done = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    str_trig = 4'b0001; tick(); str_trig = '0; tick(); tick();
    tp = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      tp += int'(o_timeout);
      if (k == 7) chk("tmo_before", {o_timeout, o_busy}, 2'b01);
      if (k == 8) chk("tmo_pulse", {o_timeout, o_busy}, 2'b10);
      if (k == 9) chk("tmo_single", 32'(o_timeout), 0);
    end
    chk("tmo_count", tp, 1);
    str_trig = 4'b0001; tick(); str_trig = '0; tick(); tick();
    tp = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) done = 1'b1;
      tick();
      tp += int'(o_timeout);
    end
    done = 1'b0; tick();
    tp += int'(o_timeout);
    chk("done_wins_idle", 32'(o_busy), 0);
    chk("done_wins_no_tmo", tp, 0);
    // disable while idle drops the count
    rst = 1'b1; tick(); rst = 1'b0; req_ready = 1'b0;
    str_trig = 4'b0010; tick(); str_trig = '0; tick();
    chk("dis_hold_src1", {o_req_valid, o_req_src}, {1'b1, 2'd1});
    for (int r = 0; r < 3; r++) begin
      str_trig[0] = 1'b1; tick(); str_trig[0] = 1'b0; tick();
    end
    chk("dis_pend", o_pending, 4'b0011);
    req_ready = 1'b1; tick(); req_ready = 1'b0; done = 1'b1; tick(); done = 1'b0;
    trig_en = 4'b1110; tick();
    chk("dis_forced0", {o_req_valid, o_pending}, 5'b0);
    tick();
    chk("dis_no_grant", {o_req_valid, o_busy}, 2'b0);
    // disable while held in GRANT
    trig_en = 4'b1111;
    str_trig = 4'b0001; tick(); str_trig = '0; tick();
    str_trig = 4'b0001; tick(); str_trig = '0; trig_en = 4'b1110; tick();
    chk("dis_held", {o_req_valid, o_req_src, o_pending}, {1'b1, 2'd0, 4'b0001});
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    chk("dis_accept", {o_req_valid, o_busy}, 2'b01);
    tick();
    chk("dis_end0", o_pending, 0);
    done = 1'b1; tick(); done = 1'b0; trig_en = 4'b1111;
    // reset during GRANT with src1 level held high
    rst = 1'b1; tick(); rst = 1'b0;
    str_trig = 4'b1000; tick(); str_trig = '0; tick();
    str_trig = 4'b1000; tick(); str_trig = '0; tick();
    chk("rst_pre", {o_req_valid, o_req_src, o_pending}, {1'b1, 2'd3, 4'b1000});
    str_trig = 4'b0010; rst = 1'b1; tick();
    chk("rst_mid", {o_req_valid, o_busy, o_pending}, 6'b0);
    rst = 1'b0; req_ready = 1'b1; done = 1'b1; g0 = 0; g1 = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (o_req_valid) begin
        if (o_req_src == 2'd1) g1++;
        else g0++;
      end
    end
    chk("rst_src1_once", g1, 1);
    chk("rst_no_other", g0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
